input_cond: RTL and testbench

Synchronises and debounces the slow board-level status inputs (user DIP switches, config DIP switches, MMC write-protect and card-detect, flash busy) before they reach the misc register block. The block sits between the CPLD pins and the misc block's read-only status inputs, so software never reads a metastable or bouncing value. It also emits a single-cycle change strobe that downstream logic can use as an event source.

---
 rtl/input_cond.sv | 136 +++++++++++++
 tb/tb_input_cond.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_cond.sv
// Two-flop synchroniser plus prescaled debounce for slow board status pins.
// Outputs are all registered; change_strb marks any debounced flip in RUN.
module input_cond #(
  parameter int PRESCALE_BITS = 14,
  parameter int STABLE_COUNT  = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [3:0] user_dip_i,
  input  logic [3:0] config_dip_i,
  input  logic       mmc_wp_i,
  input  logic       mmc_cdetect_i,
  input  logic       flash_busy_n_i,
  output logic [3:0] user_dip,
  output logic [3:0] config_dip,
  output logic       mmc_wp,
  output logic       mmc_cdetect,
  output logic       flash_busy_n,
  output logic       valid,
  output logic       change_strb
);

  localparam int         NCH     = 11;
  localparam logic [2:0] CNT_MAX = 3'(STABLE_COUNT - 1);
  // flash_busy_n idles high (not busy); every other channel idles low
  localparam logic [NCH-1:0] DEB_RST = {1'b1, 10'b00_0000_0000};

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   st_r;
  state_t                   st_nxt_s;
  logic                     load_s;
  logic [NCH-1:0]           raw_s;
  logic [NCH-1:0]           sync1_r;
  logic [NCH-1:0]           sync2_r;
  logic [PRESCALE_BITS-1:0] pre_r;
  logic                     tick_s;
  logic [2:0]               cnt_r     [NCH];
  logic [2:0]               cnt_nxt_s [NCH];
  logic [NCH-1:0]           deb_r;
  logic [NCH-1:0]           deb_nxt_s;
  logic                     flip_s;
  logic                     flip_r;
  logic                     strb_r;
  logic                     valid_r;

  assign raw_s  = {flash_busy_n_i, mmc_cdetect_i, mmc_wp_i, config_dip_i, user_dip_i};
  assign tick_s = &pre_r;

  // Control FSM: RESET -> PRIME, PRIME waits for the first tick to load deb
  always_comb begin
    st_nxt_s = st_r;
    load_s   = 1'b0;
    case (st_r)
      ST_RESET: st_nxt_s = ST_PRIME;
      ST_PRIME: begin
        if (tick_s) begin
          st_nxt_s = ST_RUN;
          load_s   = 1'b1;
        end else begin
          st_nxt_s = ST_PRIME;
        end
      end
      ST_RUN:   st_nxt_s = ST_RUN;
      default:  st_nxt_s = ST_RESET;
    endcase
  end

  // Per-channel stability counting and debounced value update
  always_comb begin
    deb_nxt_s = deb_r;
    flip_s    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (load_s) begin
        deb_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i] = 3'd0;
      end else if (st_r != ST_RUN) begin
        cnt_nxt_s[i] = 3'd0;
      end else if (sync2_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = 3'd0;
      end else if (!tick_s) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else if (cnt_r[i] == CNT_MAX) begin
        deb_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i] = 3'd0;
        flip_s       = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 3'd1;
      end
    end
  end

  // State, synchroniser, prescaler, counters and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st_r    <= ST_RESET;
      sync1_r <= '0;
      sync2_r <= '0;
      pre_r   <= '0;
      deb_r   <= DEB_RST;
      flip_r  <= 1'b0;
      strb_r  <= 1'b0;
      valid_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= 3'd0;
      end
    end else begin
      st_r    <= st_nxt_s;
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      pre_r   <= pre_r + PRESCALE_BITS'(1);
      deb_r   <= deb_nxt_s;
      // strobe lags the deb update by one clock
      flip_r  <= flip_s;
      strb_r  <= flip_r;
      valid_r <= valid_r | load_s;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign user_dip     = deb_r[3:0];
  assign config_dip   = deb_r[7:4];
  assign mmc_wp       = deb_r[8];
  assign mmc_cdetect  = deb_r[9];
  assign flash_busy_n = deb_r[10];
  assign valid        = valid_r;
  assign change_strb  = strb_r;

endmodule

// File: tb/tb_input_cond.sv
// Randomised bench for input_cond with a per-clock behavioural model and
// directed scenarios pinned by literal expectations.
module tb_input_cond;
  localparam int PB  = 2;
  localparam int SC  = 3;
  localparam int PER = 1 << PB;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] udip_i, cdip_i;
  logic       wp_i, cd_i, fb_i;
  logic [3:0] user_dip, config_dip;
  logic       mmc_wp, mmc_cdetect, flash_busy_n, valid, change_strb;

  always #5 clk = ~clk;

  input_cond #(.PRESCALE_BITS(PB), .STABLE_COUNT(SC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .user_dip_i(udip_i), .config_dip_i(cdip_i), .mmc_wp_i(wp_i),
    .mmc_cdetect_i(cd_i), .flash_busy_n_i(fb_i),
    .user_dip(user_dip), .config_dip(config_dip), .mmc_wp(mmc_wp),
    .mmc_cdetect(mmc_cdetect), .flash_busy_n(flash_busy_n),
    .valid(valid), .change_strb(change_strb)
  );

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // model: outputs as they must appear in the clock after each edge
  logic [10:0] exp_deb;
  bit          exp_valid, exp_strb;
  int          m_cnt [11];
  bit          m_primed, m_pend;
  int          m_rel;
  logic [10:0] m_hist [$];

  function automatic logic [10:0] pins();
    return {fb_i, cd_i, wp_i, cdip_i, udip_i};
  endfunction

  task automatic model_edge();
    logic [10:0] s;
    bit tick, fl;
    if (rst) begin
      exp_deb = 11'h400; exp_valid = 1'b0; exp_strb = 1'b0;
      m_primed = 1'b0; m_pend = 1'b0; m_rel = 0; m_hist.delete();
      foreach (m_cnt[c]) m_cnt[c] = 0;
    end else begin
      m_hist.push_back(pins());
      s    = (m_rel >= 2) ? m_hist[m_rel-2] : 11'h000;
      tick = (m_rel % PER) == PER - 1;
      exp_strb = m_pend;
      m_pend   = 1'b0;
      if (!m_primed) begin
        if (tick) begin
          exp_deb = s; exp_valid = 1'b1; m_primed = 1'b1;
        end
      end else begin
        fl = 1'b0;
        for (int c = 0; c < 11; c++) begin
          if (s[c] == exp_deb[c]) m_cnt[c] = 0;
          else if (tick) begin
            if (m_cnt[c] == SC - 1) begin
              exp_deb[c] = s[c]; m_cnt[c] = 0; fl = 1'b1;
            end else m_cnt[c]++;
          end
        end
        m_pend = fl;
      end
      m_rel++;
    end
  endtask

  // compare DUT against the model every clock
  always @(negedge clk) begin
    if (cmp_en) begin
      n_chk++;
      if ({change_strb, valid, flash_busy_n, mmc_cdetect, mmc_wp, config_dip, user_dip}
          !== {exp_strb, exp_valid, exp_deb}) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time,
                 {change_strb, valid, flash_busy_n, mmc_cdetect, mmc_wp, config_dip, user_dip},
                 {exp_strb, exp_valid, exp_deb});
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic rng(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
    end
  endtask

  // one edge, model update, then observe at the following negedge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, strobes, hi_seen, len;
    rst = 1'b1; udip_i = 4'hF; cdip_i = 4'hF; wp_i = 1'b1; cd_i = 1'b1; fb_i = 1'b1;
    cyc();
    cmp_en = 1'b1;

    // reset values held with all pins high
    for (int k = 0; k < 10; k++) begin
      cyc();
      lit("rst_user_dip", 32'(user_dip), 32'h0);
      lit("rst_config_dip", 32'(config_dip), 32'h0);
      lit("rst_wp_cd", 32'({mmc_wp, mmc_cdetect}), 32'h0);
      lit("rst_flash_busy_n", 32'(flash_busy_n), 32'h1);
      lit("rst_valid_strb", 32'({valid, change_strb}), 32'h0);
    end

    // priming
    udip_i = 4'b1010; cdip_i = 4'h0; wp_i = 1'b0; cd_i = 1'b0; fb_i = 1'b0;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      lit("prime_strb", 32'(change_strb), 32'h0);
      if (k == 2) lit("prime_valid_early", 32'(valid), 32'h0);
      if (k == 3) begin
        lit("prime_valid", 32'(valid), 32'h1);
        lit("prime_user_dip", 32'(user_dip), 32'hA);
        lit("prime_flash_busy_n", 32'(flash_busy_n), 32'h0);
      end
    end

    // clean step on card-detect
    cd_i = 1'b1;
    n = 0;
    while (n < 20 && mmc_cdetect !== 1'b1) begin cyc(); n++; end
    rng("clean_latency", n, 11, 14);
    lit("clean_strb_at_rise", 32'(change_strb), 32'h0);
    cyc(); lit("clean_strb", 32'(change_strb), 32'h1);
    cyc(); lit("clean_strb_end", 32'(change_strb), 32'h0);

    // 6-clock glitch must be rejected
    cdip_i[0] = 1'b1;
    repeat (6) cyc();
    cdip_i[0] = 1'b0;
    strobes = 0; hi_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (change_strb === 1'b1) strobes++;
      if (config_dip !== 4'h0) hi_seen++;
    end
    lit("glitch_config_dip", 32'(hi_seen), 32'h0);
    lit("glitch_strb", 32'(strobes), 32'h0);

    // simultaneous change: user_dip[3] 1->0, mmc_wp 0->1
    udip_i[3] = 1'b0; wp_i = 1'b1;
    n = 0; strobes = 0;
    while (n < 20 && user_dip[3] !== 1'b0) begin
      cyc(); n++;
      if (change_strb === 1'b1) strobes++;
    end
    rng("simul_latency", n, 11, 14);
    lit("simul_wp", 32'(mmc_wp), 32'h1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (change_strb === 1'b1) strobes++;
    end
    lit("simul_one_strobe", 32'(strobes), 32'h1);

    // reset mid-count, then re-prime
    fb_i = 1'b1;
    repeat (20) cyc();
    lit("pre_mid_flash_busy_n", 32'(flash_busy_n), 32'h1);
    fb_i = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    lit("mid_rst_valid", 32'(valid), 32'h0);
    lit("mid_rst_outs", 32'({flash_busy_n, mmc_cdetect, mmc_wp, config_dip, user_dip}), 32'h400);
    lit("mid_rst_strb", 32'(change_strb), 32'h0);
    repeat (2) cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      lit("reprime_strb", 32'(change_strb), 32'h0);
      if (k == 3) lit("reprime_fb_valid", 32'({flash_busy_n, valid}), 32'h1);
    end

    // randomised traffic with occasional reset pulses
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: udip_i = 4'($urandom);
          1: cdip_i = 4'($urandom);
          2: wp_i = ~wp_i;
          3: cd_i = ~cd_i;
          default: fb_i = ~fb_i;
        endcase
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        len = $urandom_range(1, 4);
        repeat (len) cyc();
        rst = 1'b0;
      end
      cyc();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
